// File: rtl/framebuffer_reader.sv
// Framebuffer scan-out reader: fetches one frame of 32-bit words over an
// Avalon-MM read master and presents them as a framed Avalon-ST pixel stream.
module framebuffer_reader #(
  parameter int H_PIXELS   = 640,
  parameter int V_LINES    = 480,
  parameter int FIFO_DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] base_addr,
  output logic [31:0] m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  input  logic        m_readdatavalid,
  output logic [23:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sop,
  output logic        out_eop,
  output logic        frame_done,
  output logic [1:0]  dbg_state
);

  // Handshakes: an Avalon-MM request transfers on a cycle with m_read=1 and
  // m_waitrequest=0 (address/read held otherwise); a pixel transfers on a
  // cycle with out_valid=1 and out_ready=1; out_valid never waits on out_ready.

  localparam int NPIX = H_PIXELS * V_LINES;
  localparam int PCW  = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int OW   = AW + 1;
  localparam logic [PCW-1:0] LAST_PIX = PCW'(NPIX - 1);
  localparam logic [OW:0]    DEPTH_C  = (OW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [31:0]    addr_q, addr_d;
  logic [PCW-1:0] req_cnt_q, req_cnt_d;
  logic [OW-1:0]  outst_q, outst_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [PCW-1:0] pix_cnt_q, pix_cnt_d;
  logic           frame_done_q, frame_done_d;
  logic [23:0]    fifo_mem [FIFO_DEPTH];

  logic issue;
  logic ret;
  logic pop;
  logic credit_ok;
  logic start_frame;
  logic unused_hi;

  assign unused_hi = ^m_readdata[31:24];

  // Outstanding plus buffered words bound the FIFO occupancy, so this credit
  // test is what guarantees the FIFO can never overflow.
  assign credit_ok   = (({1'b0, outst_q} + {1'b0, fifo_cnt_q}) < DEPTH_C);
  assign issue       = m_read && !m_waitrequest;
  // Returns with nothing outstanding are stale (issued before a reset) and dropped.
  assign ret         = m_readdatavalid && (outst_q != '0);
  assign pop         = out_valid && out_ready;
  assign start_frame = (state_q == S_IDLE) && enable;

  // ---------------- request FSM: state register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- request FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (issue && (req_cnt_q == LAST_PIX)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (outst_q == '0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- request FSM: outputs ----------------
  always_comb begin
    m_read    = 1'b0;
    dbg_state = state_q;
    if (state_q == S_FETCH) begin
      m_read = credit_ok;
    end
  end

  assign m_address = addr_q;

  // ---------------- request-side counters ----------------
  always_comb begin
    addr_d    = addr_q;
    req_cnt_d = req_cnt_q;
    if (start_frame) begin
      addr_d    = base_addr;
      req_cnt_d = '0;
    end else if (issue) begin
      addr_d    = addr_q + 32'd4;
      req_cnt_d = (req_cnt_q == LAST_PIX) ? '0 : req_cnt_q + PCW'(1);
    end
  end

  always_comb begin
    outst_d = outst_q;
    case ({issue, ret})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q    <= '0;
      req_cnt_q <= '0;
      outst_q   <= '0;
    end else begin
      addr_q    <= addr_d;
      req_cnt_q <= req_cnt_d;
      outst_q   <= outst_d;
    end
  end

  // ---------------- pixel FIFO (first-word-fall-through) ----------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (ret) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({ret, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + OW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - OW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ret) begin
      fifo_mem[wr_ptr_q] <= m_readdata[23:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // ---------------- output framing ----------------
  // The stream side counts its own pixels so framing follows accepted pixels,
  // independent of how far ahead the request side has run.
  always_comb begin
    pix_cnt_d    = pix_cnt_q;
    frame_done_d = 1'b0;
    if (pop) begin
      if (pix_cnt_q == LAST_PIX) begin
        pix_cnt_d    = '0;
        frame_done_d = 1'b1;
      end else begin
        pix_cnt_d = pix_cnt_q + PCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      pix_cnt_q    <= pix_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_valid  = (fifo_cnt_q != '0);
  assign out_data   = fifo_mem[rd_ptr_q];
  assign out_sop    = out_valid && (pix_cnt_q == '0);
  assign out_eop    = out_valid && (pix_cnt_q == LAST_PIX);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_framebuffer_reader.sv
// Randomised scoreboard bench for framebuffer_reader on a 4x2 frame with a
// 4-entry FIFO; a memory model in the bench supplies read data.
module tb_framebuffer_reader;

  localparam int H    = 4;
  localparam int V    = 2;
  localparam int FD   = 4;
  localparam int NPIX = H * V;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        enable;
  logic [31:0] base_addr;
  logic [31:0] m_address;
  logic        m_read;
  logic        m_waitrequest;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;
  logic        frame_done;
  logic [1:0]  dbg_state;

  framebuffer_reader #(.H_PIXELS(H), .V_LINES(V), .FIFO_DEPTH(FD)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .base_addr       (base_addr),
    .m_address       (m_address),
    .m_read          (m_read),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_sop         (out_sop),
    .out_eop         (out_eop),
    .frame_done      (frame_done),
    .dbg_state       (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic [25:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  pend_t       pend_q[$];
  logic [31:0] mem [logic [31:0]];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int issued_cnt = 0;
  int popped_cnt = 0;
  int fd_count   = 0;
  int stall_seen = 0;
  int frame_base = 0;
  int pop_base   = 0;
  int stall_at   = -1;
  int stall_left = 0;
  int lat_min    = 1;
  int lat_max    = 1;
  logic rand_ready = 1'b0;
  logic ready_fix  = 1'b1;
  logic rand_stall = 1'b0;
  logic chk_lat    = 1'b0;
  logic prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  logic fd_pending = 1'b0;
  logic rdv_prev   = 1'b0;
  logic [31:0] tmp_a;
  logic [25:0] tmp_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] get_mem(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom();
    return mem[a];
  endfunction

  // ---------------- memory slave and out_ready driver ----------------
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (!reset_n) begin
      pend_q.delete();
      m_readdatavalid = 1'b0;
      m_waitrequest   = 1'b0;
    end else begin
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        m_readdatavalid = 1'b1;
        m_readdata      = get_mem(pend_q[0].addr);
        void'(pend_q.pop_front());
      end else begin
        m_readdatavalid = 1'b0;
        m_readdata      = $urandom();
      end
      if (m_read && issued_cnt == stall_at && stall_left > 0) begin
        m_waitrequest = 1'b1;
        stall_left--;
      end else begin
        m_waitrequest = rand_stall && m_read && ($urandom_range(0, 5) == 0);
      end
    end
    out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : ready_fix;
  end

  // ---------------- monitor: requests, pixels, frame_done ----------------
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
      fd_pending = 1'b0;
      rdv_prev   = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_read", m_read, 1);
        check("hold_addr", m_address, prev_addr);
      end
      prev_stall = m_read && m_waitrequest;
      prev_addr  = m_address;
      if (m_read && m_waitrequest) begin
        stall_seen++;
        if (exp_addr_q.size() > 0) check("stall_addr", m_address, exp_addr_q[0]);
      end
      if (m_read && !m_waitrequest) begin
        check("credit", ((issued_cnt - popped_cnt) < FD), 1);
        if (exp_addr_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_request: got %0h want none", m_address);
        end else begin
          tmp_a = exp_addr_q.pop_front();
          check("addr", m_address, tmp_a);
        end
        pend_q.push_back('{m_address, cyc + int'($urandom_range(lat_min, lat_max))});
        issued_cnt++;
      end
      if (chk_lat && rdv_prev) begin
        check("latency", out_valid, 1);
        chk_lat = 1'b0;
      end
      rdv_prev = m_readdatavalid;
      if (fd_pending || frame_done) check("frame_done", frame_done, fd_pending);
      if (frame_done) fd_count++;
      fd_pending = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_pixel: got %0h want none", out_data);
        end else begin
          tmp_e = exp_q.pop_front();
          check("pixel", {out_sop, out_eop, out_data}, tmp_e);
        end
        popped_cnt++;
        fd_pending = out_eop;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: a frame is NPIX consecutive words from base, framed sop..eop.
  task automatic push_frame(input logic [31:0] b);
    logic [31:0] a;
    logic [31:0] d;
    for (int i = 0; i < NPIX; i++) begin
      a = b + 32'(4 * i);
      d = get_mem(a);
      exp_addr_q.push_back(a);
      exp_q.push_back({(i == 0), (i == NPIX - 1), d[23:0]});
    end
  endtask

  task automatic start_frame(input logic [31:0] b);
    base_addr  = b;
    frame_base = issued_cnt;
    pop_base   = popped_cnt;
    push_frame(b);
    enable = 1'b1;
  endtask

  task automatic wait_issued(input int n, input int limit);
    int t = 0;
    while ((issued_cnt - frame_base) < n && t < limit) begin
      tick();
      t++;
    end
    check("wait_issued", ((issued_cnt - frame_base) >= n), 1);
  endtask

  task automatic wait_popped(input int n, input int limit);
    int t = 0;
    while ((popped_cnt - pop_base) < n && t < limit) begin
      tick();
      t++;
    end
    check("wait_popped", ((popped_cnt - pop_base) >= n), 1);
  endtask

  task automatic wait_fd(input int target, input int limit);
    int t = 0;
    while (fd_count < target && t < limit) begin
      tick();
      t++;
    end
    check("wait_frame_done", (fd_count >= target), 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int fd0;
    reset_n = 1'b0;
    enable = 1'b0;
    base_addr = '0;
    out_ready = 1'b1;
    m_waitrequest = 1'b0;
    m_readdata = '0;
    m_readdatavalid = 1'b0;
    repeat (3) tick();
    check("rst_m_read", m_read, 0);
    check("rst_m_address", m_address, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sop", out_sop, 0);
    check("rst_eop", out_eop, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_state", dbg_state, 0);
    reset_n = 1'b1;
    tick();

    // Basic frame; enable dropped at pixel 3 must not abort it
    fd0 = fd_count;
    chk_lat = 1'b1;
    start_frame(32'h0000_1000);
    wait_popped(3, 100);
    enable = 1'b0;
    wait_fd(fd0 + 1, 200);
    repeat (10) tick();
    check("a_state_idle", dbg_state, 0);
    check("a_requests", issued_cnt - frame_base, NPIX);
    check("a_frames", fd_count - fd0, 1);
    check("a_latency_seen", chk_lat, 0);

    // Five-cycle waitrequest on request 3
    fd0 = fd_count;
    stall_seen = 0;
    stall_at = issued_cnt + 3;
    stall_left = 5;
    start_frame(32'h0000_1000);
    wait_issued(1, 50);
    enable = 1'b0;
    wait_fd(fd0 + 1, 300);
    repeat (5) tick();
    check("b_stall_cycles", stall_seen, 5);
    check("b_requests", issued_cnt - frame_base, NPIX);
    stall_at = -1;

    // Back-pressure: credit limit stops requests at FIFO_DEPTH
    fd0 = fd_count;
    ready_fix = 1'b0;
    start_frame(32'h0000_4000);
    repeat (40) tick();
    check("c_requests_capped", issued_cnt - frame_base, FD);
    check("c_m_read_low", m_read, 0);
    enable = 1'b0;
    ready_fix = 1'b1;
    wait_fd(fd0 + 1, 300);
    repeat (5) tick();
    check("c_requests", issued_cnt - frame_base, NPIX);

    // enable held: second frame picks up the newly sampled base
    fd0 = fd_count;
    lat_min = 1;
    lat_max = 4;
    start_frame(32'h0000_3000);
    wait_issued(1, 50);
    base_addr = 32'h0000_5000;
    push_frame(32'h0000_5000);
    wait_issued(NPIX + 1, 300);
    enable = 1'b0;
    wait_fd(fd0 + 2, 600);
    repeat (15) tick();
    check("d_state_idle", dbg_state, 0);
    check("d_requests", issued_cnt - frame_base, 2 * NPIX);

    // Reset pulse mid-fetch
    lat_min = 1;
    lat_max = 1;
    start_frame(32'h0000_6000);
    wait_issued(3, 50);
    reset_n = 1'b0;
    #1;
    check("e_m_read", m_read, 0);
    check("e_m_address", m_address, 0);
    check("e_out_valid", out_valid, 0);
    check("e_sop", out_sop, 0);
    check("e_eop", out_eop, 0);
    check("e_frame_done", frame_done, 0);
    check("e_state", dbg_state, 0);
    enable = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    issued_cnt = 0;
    popped_cnt = 0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    fd0 = fd_count;
    start_frame(32'h0000_7000);
    wait_issued(1, 50);
    enable = 1'b0;
    wait_fd(fd0 + 1, 300);

    // Random ready, latency and stalls over three frames
    rand_ready = 1'b1;
    rand_stall = 1'b1;
    lat_min = 1;
    lat_max = 8;
    for (int f = 0; f < 3; f++) begin
      repeat (4) tick();
      fd0 = fd_count;
      start_frame(32'h0001_0000 + 32'($urandom_range(0, 4095)) * 32'd16);
      wait_issued(1, 100);
      enable = 1'b0;
      wait_fd(fd0 + 1, 2000);
    end
    rand_ready = 1'b0;
    rand_stall = 1'b0;
    repeat (20) tick();
    check("end_pixels_left", exp_q.size(), 0);
    check("end_addrs_left", exp_addr_q.size(), 0);
    check("end_state_idle", dbg_state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
